pwm_regfile_mc: RTL and testbench

- Parametrised, multi-channel successor of the PWM/timer register block: NUM_CH independent channel register sets behind one access bus.
- Adds three features:
  - shadow/active double-buffering of duty and target, committed at each channel's period boundary or by global force;
  - W1C interrupt status with enable mask and registered irq_o;
  - capture-overflow flag that clears on read.
- Sits between the bus slave and the NUM_CH PWM/timer cores.

---
 rtl/pwm_regs_pkg.sv | 40 ++++
 rtl/pwm_ch_regs.sv | 109 ++++++++++
 rtl/pwm_regfile_mc.sv | 149 ++++++++++++++
 tb/tb_pwm_regfile_mc.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_regs_pkg.sv
// Shared register map for the multi-channel PWM/timer register file:
// offsets, field positions, global-space select and the ID word.
package pwm_regs_pkg;

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_DUTY_SH = 3'd1;
  localparam logic [2:0] OFF_TGT_SH  = 3'd2;
  localparam logic [2:0] OFF_CFG     = 3'd3;
  localparam logic [2:0] OFF_COUNTER = 3'd4;
  localparam logic [2:0] OFF_CMD     = 3'd5;
  localparam logic [2:0] OFF_CAPTURE = 3'd6;

  localparam logic [2:0] GOFF_IRQ_STAT = 3'd0;
  localparam logic [2:0] GOFF_IRQ_EN   = 3'd1;
  localparam logic [2:0] GOFF_ID       = 3'd2;
  localparam logic [2:0] GOFF_GUPD     = 3'd3;

  localparam int CTRL_MODE_LSB  = 0;
  localparam int CTRL_EN_BIT    = 2;
  localparam int CTRL_FREQ_LSB  = 12;
  localparam int CFG_INSEL_LSB  = 0;
  localparam int CFG_TRIG_LSB   = 4;
  localparam int CFG_OUTF_BIT   = 8;
  localparam int CFG_CAPSEL_LSB = 12;
  localparam int CMD_CLR_BIT    = 0;
  localparam int CMD_TRIG_BIT   = 4;
  localparam int CAP_RUN_BIT    = 12;
  localparam int CAP_OVF_BIT    = 15;
  localparam int GUPD_BIT       = 0;

  // Global space is selected by the address bit just above channel + offset.
  localparam int GLB_SEL_OFS = 3;

  localparam logic [7:0] ID_VERSION = 8'h02;

  function automatic logic [15:0] id_word(input int num_ch, input int cnt_w);
    return {4'(num_ch), 4'(cnt_w - 8), ID_VERSION};
  endfunction

endpackage

// File: rtl/pwm_ch_regs.sv
// One channel's register set: CTRL/CFG, duty/target shadow+active pairs,
// capture pending/overflow flags and the CMD pulse flops.
module pwm_ch_regs
  import pwm_regs_pkg::*;
#(
  parameter int CNT_W  = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr_i,
  input  logic              rd_cap_i,
  input  logic [2:0]        off_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              commit_i,
  input  logic              cap_valid_i,
  output logic [DATA_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] cfg_o,
  output logic [CNT_W-1:0]  duty_sh_o,
  output logic [CNT_W-1:0]  tgt_sh_o,
  output logic [CNT_W-1:0]  duty_o,
  output logic [CNT_W-1:0]  tgt_o,
  output logic              ovf_o,
  output logic              clear_o,
  output logic              sw_trig_o
);

  logic [DATA_W-1:0] ctrl_q, ctrl_d, cfg_q, cfg_d;
  logic [CNT_W-1:0]  duty_sh_q, duty_sh_d, tgt_sh_q, tgt_sh_d;
  logic [CNT_W-1:0]  duty_act_q, duty_act_d, tgt_act_q, tgt_act_d;
  logic              pend_q, pend_d, ovf_q, ovf_d;
  logic              clear_q, clear_d, sw_trig_q, sw_trig_d;

  always_comb begin
    ctrl_d     = ctrl_q;
    cfg_d      = cfg_q;
    duty_sh_d  = duty_sh_q;
    tgt_sh_d   = tgt_sh_q;
    duty_act_d = duty_act_q;
    tgt_act_d  = tgt_act_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    clear_d    = 1'b0;
    sw_trig_d  = 1'b0;
    // Commit reads the old shadow, so a coinciding write waits a boundary.
    if (commit_i) begin
      duty_act_d = duty_sh_q;
      tgt_act_d  = tgt_sh_q;
    end
    if (wr_i) begin
      case (off_i)
        OFF_CTRL:    ctrl_d    = wdata_i;
        OFF_DUTY_SH: duty_sh_d = wdata_i[CNT_W-1:0];
        OFF_TGT_SH:  tgt_sh_d  = wdata_i[CNT_W-1:0];
        OFF_CFG:     cfg_d     = wdata_i;
        OFF_CMD: begin
          clear_d   = wdata_i[CMD_CLR_BIT];
          sw_trig_d = wdata_i[CMD_TRIG_BIT];
        end
        default: ;
      endcase
    end
    if (rd_cap_i) begin
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end
    if (cap_valid_i) begin
      pend_d = 1'b1;
      if (pend_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctrl_q     <= '0;
      cfg_q      <= '0;
      duty_sh_q  <= '0;
      tgt_sh_q   <= '0;
      duty_act_q <= '0;
      tgt_act_q  <= '0;
      pend_q     <= 1'b0;
      ovf_q      <= 1'b0;
      clear_q    <= 1'b0;
      sw_trig_q  <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      cfg_q      <= cfg_d;
      duty_sh_q  <= duty_sh_d;
      tgt_sh_q   <= tgt_sh_d;
      duty_act_q <= duty_act_d;
      tgt_act_q  <= tgt_act_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      clear_q    <= clear_d;
      sw_trig_q  <= sw_trig_d;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign cfg_o     = cfg_q;
  assign duty_sh_o = duty_sh_q;
  assign tgt_sh_o  = tgt_sh_q;
  assign duty_o    = duty_act_q;
  assign tgt_o     = tgt_act_q;
  assign ovf_o     = ovf_q;
  assign clear_o   = clear_q;
  assign sw_trig_o = sw_trig_q;

endmodule

// File: rtl/pwm_regfile_mc.sv
// Multi-channel PWM/timer register file: address decode, read mux, global
// IRQ status/enable and per-channel register sets.
module pwm_regfile_mc
  import pwm_regs_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 10,
  parameter int DATA_W = 16,
  localparam int CH_AW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ADDR_W = CH_AW + 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    acc_en_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [DATA_W-1:0]       rdata_o,
  output logic [2*NUM_CH-1:0]     mode_o,
  output logic [NUM_CH-1:0]       enable_o,
  output logic [2*NUM_CH-1:0]     freq_sel_o,
  output logic [CNT_W*NUM_CH-1:0] duty_o,
  output logic [CNT_W*NUM_CH-1:0] target_o,
  output logic [4*NUM_CH-1:0]     input_sel_o,
  output logic [2*NUM_CH-1:0]     trig_sel_o,
  output logic [NUM_CH-1:0]       out_func_o,
  output logic [2*NUM_CH-1:0]     cap_sel_o,
  output logic [NUM_CH-1:0]       clear_o,
  output logic [NUM_CH-1:0]       sw_trig_o,
  input  logic [NUM_CH-1:0]       period_end_i,
  input  logic [NUM_CH-1:0]       match_i,
  input  logic [NUM_CH-1:0]       cap_valid_i,
  input  logic [CNT_W*NUM_CH-1:0] counter_i,
  input  logic [CNT_W*NUM_CH-1:0] captured_i,
  input  logic [NUM_CH-1:0]       running_i,
  output logic                    irq_o
);

  localparam int IW = 2 * NUM_CH;

  logic             wr, rd, glb, ch_ok, gupd;
  logic [CH_AW-1:0] ch_idx;
  logic [2:0]       off;

  assign wr     = acc_en_i & wr_en_i;
  assign rd     = acc_en_i & ~wr_en_i;
  assign glb    = addr_i[CH_AW + GLB_SEL_OFS];
  assign ch_idx = addr_i[CH_AW+2:3];
  assign off    = addr_i[2:0];
  assign ch_ok  = ({1'b0, ch_idx} < (CH_AW+1)'(NUM_CH));
  assign gupd   = wr & glb & (off == GOFF_GUPD) & wdata_i[GUPD_BIT];

  logic [DATA_W-1:0] ctrl_a [NUM_CH];
  logic [DATA_W-1:0] cfg_a  [NUM_CH];
  logic [DATA_W-1:0] cnt_a  [NUM_CH];
  logic [DATA_W-1:0] cap_a  [NUM_CH];
  logic [CNT_W-1:0]  dsh_a  [NUM_CH];
  logic [CNT_W-1:0]  tsh_a  [NUM_CH];
  logic [NUM_CH-1:0] ovf_v;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = ~glb & (ch_idx == CH_AW'(c));

    pwm_ch_regs #(.CNT_W(CNT_W), .DATA_W(DATA_W)) u_ch (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .wr_i        (wr & sel),
      .rd_cap_i    (rd & sel & (off == OFF_CAPTURE)),
      .off_i       (off),
      .wdata_i     (wdata_i),
      .commit_i    (period_end_i[c] | gupd),
      .cap_valid_i (cap_valid_i[c]),
      .ctrl_o      (ctrl_a[c]),
      .cfg_o       (cfg_a[c]),
      .duty_sh_o   (dsh_a[c]),
      .tgt_sh_o    (tsh_a[c]),
      .duty_o      (duty_o[c*CNT_W +: CNT_W]),
      .tgt_o       (target_o[c*CNT_W +: CNT_W]),
      .ovf_o       (ovf_v[c]),
      .clear_o     (clear_o[c]),
      .sw_trig_o   (sw_trig_o[c])
    );

    assign mode_o[2*c +: 2]      = ctrl_a[c][CTRL_MODE_LSB +: 2];
    assign enable_o[c]           = ctrl_a[c][CTRL_EN_BIT];
    assign freq_sel_o[2*c +: 2]  = ctrl_a[c][CTRL_FREQ_LSB +: 2];
    assign input_sel_o[4*c +: 4] = cfg_a[c][CFG_INSEL_LSB +: 4];
    assign trig_sel_o[2*c +: 2]  = cfg_a[c][CFG_TRIG_LSB +: 2];
    assign out_func_o[c]         = cfg_a[c][CFG_OUTF_BIT];
    assign cap_sel_o[2*c +: 2]   = cfg_a[c][CFG_CAPSEL_LSB +: 2];
    assign cnt_a[c] = DATA_W'(counter_i[c*CNT_W +: CNT_W]);
    assign cap_a[c] = DATA_W'(captured_i[c*CNT_W +: CNT_W])
                    | (DATA_W'(running_i[c]) << CAP_RUN_BIT)
                    | (DATA_W'(ovf_v[c]) << CAP_OVF_BIT);
  end

  logic [IW-1:0] stat_q, stat_d, en_q, en_d;
  logic          irq_q, irq_d;

  always_comb begin
    stat_d = stat_q;
    en_d   = en_q;
    // Fresh events land after the W1C mask so a coinciding event survives.
    if (wr & glb & (off == GOFF_IRQ_STAT)) stat_d = stat_d & ~wdata_i[IW-1:0];
    stat_d = stat_d | {match_i, cap_valid_i};
    if (wr & glb & (off == GOFF_IRQ_EN)) en_d = wdata_i[IW-1:0];
    irq_d = |(stat_q & en_q);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stat_q <= '0;
      en_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      en_q   <= en_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_o = irq_q;

  always_comb begin
    rdata_o = '0;
    if (rd) begin
      if (glb) begin
        case (off)
          GOFF_IRQ_STAT: rdata_o = DATA_W'(stat_q);
          GOFF_IRQ_EN:   rdata_o = DATA_W'(en_q);
          GOFF_ID:       rdata_o = DATA_W'(id_word(NUM_CH, CNT_W));
          default:       rdata_o = '0;
        endcase
      end else if (ch_ok) begin
        case (off)
          OFF_CTRL:    rdata_o = ctrl_a[ch_idx];
          OFF_DUTY_SH: rdata_o = DATA_W'(dsh_a[ch_idx]);
          OFF_TGT_SH:  rdata_o = DATA_W'(tsh_a[ch_idx]);
          OFF_CFG:     rdata_o = cfg_a[ch_idx];
          OFF_COUNTER: rdata_o = cnt_a[ch_idx];
          OFF_CAPTURE: rdata_o = cap_a[ch_idx];
          default:     rdata_o = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_regfile_mc.sv
// Directed + random bench for pwm_regfile_mc against a per-register
// behavioural model held in plain arrays.
module tb_pwm_regfile_mc;
  localparam int NCH = 4, CW = 10, DW = 16, AW = 6;

  logic clk_i = 0, rstn_i = 0, acc_en_i = 0, wr_en_i = 0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic [DW-1:0] rdata_o;
  logic [2*NCH-1:0] mode_o, freq_sel_o, trig_sel_o, cap_sel_o;
  logic [NCH-1:0] enable_o, out_func_o, clear_o, sw_trig_o;
  logic [CW*NCH-1:0] duty_o, target_o;
  logic [4*NCH-1:0] input_sel_o;
  logic [NCH-1:0] period_end_i = '0, match_i = '0, cap_valid_i = '0, running_i = '0;
  logic [CW*NCH-1:0] counter_i = '0, captured_i = '0;
  logic irq_o;

  pwm_regfile_mc #(.NUM_CH(NCH), .CNT_W(CW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .acc_en_i(acc_en_i), .wr_en_i(wr_en_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .mode_o(mode_o),
    .enable_o(enable_o), .freq_sel_o(freq_sel_o), .duty_o(duty_o),
    .target_o(target_o), .input_sel_o(input_sel_o), .trig_sel_o(trig_sel_o),
    .out_func_o(out_func_o), .cap_sel_o(cap_sel_o), .clear_o(clear_o),
    .sw_trig_o(sw_trig_o), .period_end_i(period_end_i), .match_i(match_i),
    .cap_valid_i(cap_valid_i), .counter_i(counter_i), .captured_i(captured_i),
    .running_i(running_i), .irq_o(irq_o));

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;

  // reference state
  logic [15:0] m_ctrl [NCH], m_cfg [NCH];
  logic [9:0]  m_dsh [NCH], m_tsh [NCH], m_dact [NCH], m_tact [NCH];
  logic        m_pend [NCH], m_ovf [NCH], m_clr [NCH], m_trg [NCH];
  logic [7:0]  m_stat, m_en;
  logic        m_irq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ctrl[c] = 0; m_cfg[c] = 0; m_dsh[c] = 0; m_tsh[c] = 0;
      m_dact[c] = 0; m_tact[c] = 0; m_pend[c] = 0; m_ovf[c] = 0;
      m_clr[c] = 0; m_trg[c] = 0;
    end
    m_stat = 0; m_en = 0; m_irq = 0;
  endtask

  // Apply one clock edge's worth of register-map rules to the model.
  task automatic mdl_edge();
    logic w, r, g, gupd, novf;
    int ch, off;
    w = acc_en_i & wr_en_i;
    r = acc_en_i & ~wr_en_i;
    g = addr_i[5];
    ch = int'(addr_i[4:3]);
    off = int'(addr_i[2:0]);
    gupd = w && g && off == 3 && wdata_i[0];
    m_irq = |(m_stat & m_en);
    for (int c = 0; c < NCH; c++) begin
      if (period_end_i[c] || gupd) begin
        m_dact[c] = m_dsh[c];
        m_tact[c] = m_tsh[c];
      end
      m_clr[c] = 0; m_trg[c] = 0;
      if (w && !g && ch == c) begin
        case (off)
          0: m_ctrl[c] = wdata_i;
          1: m_dsh[c] = wdata_i[9:0];
          2: m_tsh[c] = wdata_i[9:0];
          3: m_cfg[c] = wdata_i;
          5: begin m_clr[c] = wdata_i[0]; m_trg[c] = wdata_i[4]; end
          default: ;
        endcase
      end
      novf = cap_valid_i[c] && m_pend[c];
      if (r && !g && ch == c && off == 6) begin m_pend[c] = 0; m_ovf[c] = 0; end
      if (cap_valid_i[c]) m_pend[c] = 1;
      if (novf) m_ovf[c] = 1;
    end
    if (w && g && off == 0) m_stat = m_stat & ~wdata_i[7:0];
    m_stat = m_stat | {match_i, cap_valid_i};
    if (w && g && off == 1) m_en = wdata_i[7:0];
  endtask

  function automatic logic [15:0] mdl_read(input logic [AW-1:0] a);
    int ch, off;
    ch = int'(a[4:3]);
    off = int'(a[2:0]);
    if (a[5]) begin
      case (off)
        0: return {8'h0, m_stat};
        1: return {8'h0, m_en};
        2: return 16'h4202;
        default: return 16'h0;
      endcase
    end
    case (off)
      0: return m_ctrl[ch];
      1: return {6'h0, m_dsh[ch]};
      2: return {6'h0, m_tsh[ch]};
      3: return m_cfg[ch];
      4: return {6'h0, counter_i[ch*CW +: CW]};
      6: return {m_ovf[ch], 2'b00, running_i[ch], 2'b00, captured_i[ch*CW +: CW]};
      default: return 16'h0;
    endcase
  endfunction

  task automatic check_outs();
    logic [2*NCH-1:0] e_mode, e_freq, e_trig, e_cap;
    logic [NCH-1:0] e_en, e_outf, e_clr, e_trg;
    logic [CW*NCH-1:0] e_duty, e_tgt;
    logic [4*NCH-1:0] e_insel;
    for (int c = 0; c < NCH; c++) begin
      e_mode[2*c +: 2] = m_ctrl[c][1:0];
      e_en[c] = m_ctrl[c][2];
      e_freq[2*c +: 2] = m_ctrl[c][13:12];
      e_insel[4*c +: 4] = m_cfg[c][3:0];
      e_trig[2*c +: 2] = m_cfg[c][5:4];
      e_outf[c] = m_cfg[c][8];
      e_cap[2*c +: 2] = m_cfg[c][13:12];
      e_duty[c*CW +: CW] = m_dact[c];
      e_tgt[c*CW +: CW] = m_tact[c];
      e_clr[c] = m_clr[c];
      e_trg[c] = m_trg[c];
    end
    chk("mode", mode_o, e_mode);
    chk("enable", enable_o, e_en);
    chk("freq_sel", freq_sel_o, e_freq);
    chk("input_sel", input_sel_o, e_insel);
    chk("trig_sel", trig_sel_o, e_trig);
    chk("out_func", out_func_o, e_outf);
    chk("cap_sel", cap_sel_o, e_cap);
    chk("duty", duty_o, e_duty);
    chk("target", target_o, e_tgt);
    chk("clear", clear_o, e_clr);
    chk("sw_trig", sw_trig_o, e_trg);
    chk("irq", irq_o, m_irq);
  endtask

  task automatic tick();
    mdl_edge();
    @(posedge clk_i);
    #1;
    check_outs();
  endtask

  function automatic logic [AW-1:0] ca(input int ch, input int off);
    return {1'b0, 2'(ch), 3'(off)};
  endfunction

  function automatic logic [AW-1:0] ga(input int off);
    return {3'b100, 3'(off)};
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    acc_en_i = 1; wr_en_i = 1; addr_i = a; wdata_i = d;
    tick();
    acc_en_i = 0; wr_en_i = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [15:0] exp, input string tag);
    acc_en_i = 1; wr_en_i = 0; addr_i = a;
    #1;
    chk(tag, rdata_o, exp);
    tick();
    acc_en_i = 0;
  endtask

  initial begin
    mdl_reset();
    #12;
    check_outs();
    chk("rst_rdata", rdata_o, 16'h0);
    chk("rst_duty", duty_o, 40'h0);
    @(negedge clk_i) rstn_i = 1;
    tick();

    // shadow only, then commit on period_end[2]
    wr(ca(2, 1), 16'h0155);
    chk("sh_no_commit", duty_o, 40'h0);
    rd(ca(2, 1), 16'h0155, "duty_sh_rd");
    period_end_i = 4'b0100; tick(); period_end_i = 0;
    chk("pe_duty_ch2", duty_o, {10'h0, 10'h155, 20'h0});

    // write coinciding with commit keeps the pre-write shadow
    period_end_i = 4'b0010;
    wr(ca(1, 2), 16'h03FF);
    period_end_i = 0;
    chk("coinc_tgt_ch1", target_o, 40'h0);
    period_end_i = 4'b0010; tick(); period_end_i = 0;
    chk("next_pe_tgt_ch1", target_o, {20'h0, 10'h3FF, 10'h0});
    wr(ca(0, 1), 16'h00AA);
    wr(ca(3, 2), 16'h0123);
    wr(ga(3), 16'h0001);
    chk("gupd_duty", duty_o, {10'h0, 10'h155, 10'h0, 10'h0AA});
    chk("gupd_tgt", target_o, {10'h123, 10'h0, 10'h3FF, 10'h0});

    // CMD pulses
    wr(ca(0, 5), 16'h0011);
    chk("cmd_clear", clear_o, 4'b0001);
    chk("cmd_trig", sw_trig_o, 4'b0001);
    tick();
    chk("cmd_clear_end", clear_o, 4'b0000);
    chk("cmd_trig_end", sw_trig_o, 4'b0000);
    rd(ca(0, 5), 16'h0, "cmd_rd");

    // capture overflow
    captured_i[3*CW +: CW] = 10'h2A5; running_i = 4'b1000;
    cap_valid_i = 4'b1000; tick(); tick(); cap_valid_i = 0;
    rd(ca(3, 6), 16'h92A5, "cap_ovf");
    rd(ca(3, 6), 16'h12A5, "cap_clr");
    cap_valid_i = 4'b1000;
    rd(ca(3, 6), 16'h12A5, "cap_rd_coinc");
    tick();
    cap_valid_i = 0;
    rd(ca(3, 6), 16'h92A5, "cap_setwins");

    // IRQ status / enable
    wr(ga(0), 16'h00FF);
    wr(ga(1), 16'h0001);
    cap_valid_i = 4'b0001; tick(); cap_valid_i = 0;
    chk("irq_lag", irq_o, 1'b0);
    rd(ga(0), 16'h0001, "irq_stat");
    chk("irq_set", irq_o, 1'b1);
    wr(ga(0), 16'h0001);
    tick();
    chk("irq_clr", irq_o, 1'b0);
    cap_valid_i = 4'b0001;
    wr(ga(0), 16'h0001);
    cap_valid_i = 0;
    rd(ga(0), 16'h0001, "w1c_setwins");

    // ID and unmapped space
    rd(ga(2), 16'h4202, "id");
    rd(ca(1, 7), 16'h0, "unmapped_ch");
    rd(ga(5), 16'h0, "unmapped_glb");

    // asynchronous reset mid-pulse with shadows loaded
    wr(ca(1, 0), 16'h3007);
    wr(ca(1, 5), 16'h0011);
    chk("pre_rst_clear", clear_o, 4'b0010);
    rstn_i = 0;
    #1;
    mdl_reset();
    check_outs();
    chk("rst_mid_clear", clear_o, 4'b0);
    chk("rst_mid_duty", duty_o, 40'h0);
    chk("rst_mid_rdata", rdata_o, 16'h0);
    @(negedge clk_i) rstn_i = 1;
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      acc_en_i = 1'($urandom_range(0, 1));
      wr_en_i = 1'($urandom_range(0, 1));
      addr_i = AW'($urandom);
      wdata_i = DW'($urandom);
      period_end_i = 4'($urandom & $urandom);
      match_i = 4'($urandom & $urandom);
      cap_valid_i = 4'($urandom & $urandom);
      counter_i = 40'({$urandom, $urandom});
      captured_i = 40'({$urandom, $urandom});
      running_i = 4'($urandom);
      #1;
      if (acc_en_i && !wr_en_i) chk("rnd_rd", rdata_o, mdl_read(addr_i));
      else chk("rnd_idle_rd", rdata_o, 16'h0);
      tick();
    end
    acc_en_i = 0; wr_en_i = 0; period_end_i = 0; match_i = 0; cap_valid_i = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
